// File: rtl/mux_result_fifo.sv
// Result FIFO behind the 4:1 mux: stores {sel, y} pairs and releases them on a
// valid/ready stream, flagging dropped pushes with a sticky overflow bit.
module mux_result_fifo #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_y,
  input  logic [SEL_W-1:0]           in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_y,
  output logic [SEL_W-1:0]           out_sel,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + SEL_W;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] head;

  // Status comes only from the registered pointers; the extra wrap bit tells full from empty.
  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign count     = wr_ptr - rd_ptr;
  assign out_valid = !empty;

  assign pop  = out_valid & out_ready;
  assign push = in_valid & (!full | pop);
  assign drop = in_valid & full & !pop;

  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign out_y   = head[DATA_W-1:0];
  assign out_sel = head[EW-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_sel, in_y};
  end

  // A drop in the same cycle as a clear still leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_mux_result_fifo.sv
// Randomised and directed bench for mux_result_fifo, checked every cycle
// against a queue-based model of the FIFO plus pinned literal expectations.
module tb_mux_result_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_y;
  logic [1:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic [1:0] out_sel;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_ovf;

  logic [5:0] model_q [$];
  logic       model_ovf = 1'b0;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  mux_result_fifo #(.DATA_W(4), .SEL_W(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_y(in_y), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_sel(out_sel),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] mux4(input logic [3:0] a, b, c, d, input logic [1:0] s);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  // Drive one cycle of inputs, then advance the model by the FIFO rules at that edge.
  task automatic applyStimulus(input logic v, input logic [3:0] y, input logic [1:0] s,
                               input logic rdy, input logic clr);
    logic mfull, mpop, mpush, mdrop;
    in_valid = v; in_y = y; in_sel = s; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    mfull = (model_q.size() == DEPTH);
    mpop  = (model_q.size() != 0) && rdy;
    mpush = v && (!mfull || mpop);
    mdrop = v && mfull && !mpop;
    if (mpop)  void'(model_q.pop_front());
    if (mpush) model_q.push_back({s, y});
    if (mdrop)     model_ovf = 1'b1;
    else if (clr)  model_ovf = 1'b0;
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 4'h0, 2'd0, rdy, 1'b0);
  endtask

  task automatic checkOutput();
    int         n;
    logic [5:0] hd;
    n  = model_q.size();
    hd = (n != 0) ? model_q[0] : 6'd0;
    checkValue("out_valid", out_valid, n != 0);
    checkValue("out_y", out_y, hd[3:0]);
    checkValue("out_sel", out_sel, hd[5:4]);
    checkValue("count", count, n);
    checkValue("full", full, n == DEPTH);
    checkValue("empty", empty, n == 0);
    checkValue("overflow", overflow, model_ovf);
  endtask

  always @(negedge clk) checkOutput();

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_y = '0; in_sel = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single pass with out_ready already high.
    applyStimulus(1'b1, 4'hA, 2'd2, 1'b1, 1'b0);
    checkValue("pass_valid", out_valid, 1);
    checkValue("pass_y", out_y, 4'hA);
    checkValue("pass_sel", out_sel, 2);
    idle(1'b1);
    checkValue("pass_empty", empty, 1);

    // Fill, drop a ninth entry, drain in order.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(i), 2'(i), 1'b0, 1'b0);
    checkValue("fill_full", full, 1);
    checkValue("fill_count", count, 8);
    applyStimulus(1'b1, 4'hF, 2'd3, 1'b0, 1'b0);
    checkValue("fill_ovf", overflow, 1);
    checkValue("fill_count9", count, 8);
    for (int i = 0; i < 8; i++) begin
      checkValue("drain_y", out_y, i);
      idle(1'b1);
    end
    checkValue("drain_empty", empty, 1);
    applyStimulus(1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    checkValue("clr_ovf0", overflow, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(i), 2'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h9, 2'd1, 1'b1, 1'b0);
    checkValue("pp_count", count, 8);
    checkValue("pp_ovf", overflow, 0);
    checkValue("pp_head", out_y, 1);
    for (int i = 0; i < 8; i++) begin
      checkValue("pp_drain_y", out_y, (i < 7) ? i + 1 : 9);
      idle(1'b1);
    end

    // Backpressure with mux-generated results.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a, b, c, d;
      logic [1:0] s;
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      s = 2'($urandom);
      applyStimulus(1'b1, mux4(a, b, c, d, s), s, 1'($urandom), 1'b0);
    end
    for (int i = 0; i < 12; i++) idle(1'($urandom));
    for (int i = 0; i < 10; i++) idle(1'b1);
    applyStimulus(1'b0, 4'h0, 2'd0, 1'b0, 1'b1);

    // Sticky overflow: set wins over a simultaneous clear.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(i + 3), 2'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hE, 2'd0, 1'b0, 1'b0);
    checkValue("sticky_set", overflow, 1);
    applyStimulus(1'b1, 4'hD, 2'd1, 1'b0, 1'b1);
    checkValue("sticky_hold", overflow, 1);
    applyStimulus(1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    checkValue("sticky_clr", overflow, 0);

    // Async reset mid-stream with 5 entries and overflow set.
    applyStimulus(1'b1, 4'hC, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    checkValue("pre_rst_count", count, 5);
    in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    rst_n = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    checkValue("rst_count", count, 0);
    checkValue("rst_empty", empty, 1);
    checkValue("rst_valid", out_valid, 0);
    checkValue("rst_y", out_y, 0);
    checkValue("rst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Free-running random traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom),
                    1'($urandom), ($urandom_range(0, 7) == 0));
    for (int i = 0; i < 10; i++) idle(1'b1);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
